// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams instruction words into imem and holds the core in reset until the image is complete.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing mod-2^32 checksum beat before release.
module imem_boot_loader #(
    parameter int DEPTH_WORDS   = 64,
    parameter int ADDR_W        = 32,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD, CHECK, WAIT, RUN, ERROR} state_t;
`else
    typedef enum logic [2:0] {LOAD, WAIT, RUN, ERROR} state_t;
`endif

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [3:0]       dcnt;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]      sum;
`endif

    // s_ready is registered from the next state, so a beat is accepted only when the register already shows 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            index      <= '0;
            dcnt       <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_W'({index, 2'b00});
                        imem_wdata <= s_data;
                        index      <= index + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        sum        <= sum + s_data;
`endif
                        if (s_last) begin
`ifdef BOOT_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= WAIT;
                            dcnt    <= 4'(RELEASE_DELAY);
                            s_ready <= 1'b0;
`endif
                        end else if (index == LAST_IDX) begin
                            // Overflow: the word above is still written, then loading stops.
                            state   <= ERROR;
                            error   <= 1'b1;
                            s_ready <= 1'b0;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (s_valid && s_ready) begin
                        s_ready <= 1'b0;
                        if (sum == s_data) begin
                            state <= WAIT;
                            dcnt  <= 4'(RELEASE_DELAY);
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                WAIT: begin
                    s_ready <= 1'b0;
                    if (dcnt == 4'd0) begin
                        state      <= RUN;
                        core_rst_n <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 4'd1;
                    end
                end
                RUN: begin
                    s_ready <= 1'b0;
                end
                ERROR: begin
                    s_ready <= 1'b0;
                end
                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader that sits directly upstream of the single-cycle RISC-V core top. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the core's instruction memory. It holds the core in reset until the image is complete, then releases it. Load faults (overflow, and checksum mismatch when enabled) keep the core in reset with a sticky error flag.

## Interface
Parameters:
- DEPTH_WORDS, 64: instruction memory capacity in 32-bit words.
- ADDR_W, 32: width of the byte address driven to instruction memory.
- RELEASE_DELAY, 2: cycles between the last imem write and core reset release; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  load-stream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  32  instruction word (or checksum word, see Configuration).
- s_last  in  1  marks the final program word.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address, word index × 4.
- imem_wdata  out  32  word to write.
- core_rst_n  out  1  active-low reset to the core top; low while loading.
- done  out  1  image loaded and core released; sticky.
- error  out  1  load fault; sticky until rst.

## Operation
- A beat is accepted when s_valid && s_ready are both high at a rising edge.
- States and transitions:
  - LOAD → LOAD: accepted beat, s_last=0, index < DEPTH_WORDS-1.
  - LOAD → ERROR: accepted beat with s_last=0 at index DEPTH_WORDS-1 (overflow). That word is still written.
  - LOAD → WAIT: accepted beat with s_last=1 (checksum off).
  - LOAD → CHECK: accepted beat with s_last=1 (checksum on).
  - CHECK → WAIT or ERROR: see Configuration.
  - WAIT → RUN: delay counter reaches zero.
  - RUN and ERROR are terminal until rst.
- s_ready = 1 only in LOAD (and in CHECK when checksum is enabled). It is 0 in WAIT, RUN and ERROR. Beats offered in those states are ignored and generate no writes.
- Word index is 0 after reset and increments by 1 per accepted program word. imem_addr = index × 4, zero-extended/truncated to ADDR_W.
- core_rst_n is 0 in every state except RUN. done = 1 only in RUN. error = 1 only in ERROR.
- Reset values: state LOAD, index 0, s_ready 0 during reset (1 from the first edge after rst rises), imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, done 0, error 0, delay counter 0.
- rst asserted mid-load returns to LOAD immediately. Already-written imem contents are not cleared. The next image overwrites from address 0.

## Timing
- Write latency 1: a beat accepted at edge N drives imem_we=1, imem_addr and imem_wdata from N until N+1. imem_we is never high for two words without two accepted beats.
- Back-to-back beats are sustained at 1 word/cycle in LOAD.
- Release: the delay counter loads RELEASE_DELAY on entry to WAIT and decrements each cycle. core_rst_n and done rise at edge N+1+RELEASE_DELAY, where N is the edge accepting the last program word (or the checksum word when enabled).
- Entry to ERROR takes effect at the accepting edge. error is high from that edge onward.
- s_valid may drop at any time without penalty. s_data and s_last are sampled only on accepting edges.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - A 32-bit running sum, modulo 2^32, of all accepted program words is kept; it resets to 0.
  - After the s_last word, the loader enters CHECK with s_ready=1 and accepts exactly one further beat as the checksum. That beat is not written to imem, and its s_last is ignored.
  - Match → WAIT. Mismatch → ERROR.
- BOOT_CHECKSUM_EN undefined:
  - No sum register and no CHECK state.
  - s_last goes straight to WAIT.

## Test plan
- Reset then 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on third), RELEASE_DELAY=2 → writes at addr 0x0, 0x4, 0x8 on consecutive cycles. core_rst_n and done rise 3 cycles after the third accept edge.
- Gapped s_valid (1,0,0,1 pattern) over 2 words → exactly 2 imem_we pulses, addresses 0x0 and 0x4, with no duplicate writes.
- DEPTH_WORDS=4, 5 words with no s_last → 4 writes (0x0–0xC), error=1 after the 4th accept, s_ready=0, core_rst_n stays 0.
- Beats offered in RUN (after done) → s_ready=0, no imem_we, done remains 1.
- rst pulsed low after 2 of 4 words → all outputs return to reset values. Reload of 4 words restarts at addr 0x0 and completes normally.
- BOOT_CHECKSUM_EN on, words 0x1, 0x2 plus checksum 0x3 → done. Same words plus checksum 0x4 → error=1, only 2 writes, core_rst_n stays 0.
